dma_command_tracker_multi: RTL and testbench

- Tracks up to NUM_CMDS outstanding DMA read commands, each tagged with a ROB id and a byte count.
- Decrements each command's remaining byte count as partial read responses return, and emits a completion carrying the tag once the count reaches zero.
- Generalises the two-entry tracker: configurable depth, tag and byte widths, optional in-order completion, a sticky protocol-error flag and an occupancy count.
- Sits between the load/store controller (alloc, completion) and the DMA reader (returned responses).

---
 rtl/dma_tracker_pkg.sv | 20 ++
 rtl/dma_tracker_order_fifo.sv | 54 +++++
 rtl/dma_command_tracker_multi.sv | 161 ++++++++++++++++
 tb/tb_dma_command_tracker_multi.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_tracker_pkg.sv
// Shared slot state encoding and derived-width helpers for the DMA command tracker.
package dma_tracker_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } slot_state_t;

   // Slot index width: at least one bit even for tiny trackers.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Occupancy counter width: must hold the value n itself.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/dma_tracker_order_fifo.sv
// Allocation-order FIFO of slot ids; its head is the only slot allowed to complete in in-order mode.
module dma_tracker_order_fifo
   import dma_tracker_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         empty
);

   localparam int PTR_W = id_width(DEPTH);
   localparam int CNT_W = cnt_width(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (int'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
   endfunction

   // NOTE: the payload array is not reset; pointers and count alone decide which entries are meaningful.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values together.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/dma_command_tracker_multi.sv
// Tracks outstanding DMA read commands per slot, counts down returned bytes and issues tagged completions.
module dma_command_tracker_multi
   import dma_tracker_pkg::*;
#(
   parameter  int NUM_CMDS   = 2,
   parameter  int TAG_WIDTH  = 6,
   parameter  int BYTE_WIDTH = 15,
   parameter  int IN_ORDER   = 0,
   localparam int ID_W       = id_width(NUM_CMDS),
   localparam int CNT_W      = cnt_width(NUM_CMDS)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  io_alloc_valid,
   input  logic [TAG_WIDTH-1:0]  io_alloc_bits_tag_rob_id,
   input  logic [BYTE_WIDTH-1:0] io_alloc_bits_bytes_to_read,
   output logic                  io_alloc_ready,
   output logic [ID_W-1:0]       io_alloc_bits_cmd_id,
   input  logic                  io_request_returned_valid,
   input  logic [BYTE_WIDTH-1:0] io_request_returned_bits_bytes_read,
   input  logic [ID_W-1:0]       io_request_returned_bits_cmd_id,
   output logic                  io_cmd_completed_valid,
   output logic [TAG_WIDTH-1:0]  io_cmd_completed_bits_tag_rob_id,
   input  logic                  io_cmd_completed_ready,
   output logic [CNT_W-1:0]      io_busy_count,
   output logic                  io_error
);

   typedef struct packed {
      slot_state_t           state;
      logic [TAG_WIDTH-1:0]  tag;
      logic [BYTE_WIDTH-1:0] remaining;
   } slot_t;

   slot_t                 slots [NUM_CMDS];
   logic                  error_q;
   logic                  free_found, done_found, head_done;
   logic [ID_W-1:0]       free_id, done_id, comp_id;
   logic                  comp_sel_valid;
   logic [TAG_WIDTH-1:0]  comp_tag;
   logic [CNT_W-1:0]      busy;
   logic                  ret_active;
   logic [BYTE_WIDTH-1:0] ret_remaining;
   logic                  fifo_empty;
   logic [ID_W-1:0]       fifo_head;
   logic                  alloc_fire, comp_fire, ret_error;

   // NOTE: each always_comb assigns defaults first so no path can infer a latch.
   always_comb begin
      free_found = 1'b0;
      free_id    = '0;
      done_found = 1'b0;
      done_id    = '0;
      busy       = '0;
      // Scan downwards so the lowest matching index wins.
      for (int i = NUM_CMDS - 1; i >= 0; i--) begin
         if (slots[i].state == FREE) begin
            free_found = 1'b1;
            free_id    = ID_W'(i);
         end
         if (slots[i].state == DONE) begin
            done_found = 1'b1;
            done_id    = ID_W'(i);
         end
         if (slots[i].state != FREE) busy = busy + CNT_W'(1);
      end
   end

   always_comb begin
      ret_active    = 1'b0;
      ret_remaining = '0;
      for (int i = 0; i < NUM_CMDS; i++) begin
         if (io_request_returned_bits_cmd_id == ID_W'(i) && slots[i].state == ACTIVE) begin
            ret_active    = 1'b1;
            ret_remaining = slots[i].remaining;
         end
      end
   end

   always_comb begin
      head_done      = 1'b0;
      comp_sel_valid = 1'b0;
      comp_id        = done_id;
      comp_tag       = '0;
      if (IN_ORDER != 0) begin
         comp_id = fifo_empty ? '0 : fifo_head;
         for (int i = 0; i < NUM_CMDS; i++) begin
            if (comp_id == ID_W'(i) && slots[i].state == DONE) head_done = 1'b1;
         end
         comp_sel_valid = !fifo_empty && head_done;
      end else begin
         comp_sel_valid = done_found;
      end
      for (int i = 0; i < NUM_CMDS; i++) begin
         if (comp_sel_valid && comp_id == ID_W'(i)) comp_tag = slots[i].tag;
      end
   end

   assign alloc_fire = io_alloc_valid && free_found;
   assign comp_fire  = comp_sel_valid && io_cmd_completed_ready;
   // Out-of-range ids never match a slot, so they land in the !ret_active case.
   assign ret_error  = io_request_returned_valid &&
                       (!ret_active || io_request_returned_bits_bytes_read > ret_remaining);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CMDS; i++) begin
            slots[i] <= '{state: FREE, tag: '0, remaining: '0};
         end
         error_q <= 1'b0;
      end else begin
         // Alloc, return and completion always hit slots in different states, hence distinct slots.
         for (int i = 0; i < NUM_CMDS; i++) begin
            if (alloc_fire && free_id == ID_W'(i)) begin
               slots[i].state     <= (io_alloc_bits_bytes_to_read == '0) ? DONE : ACTIVE;
               slots[i].tag       <= io_alloc_bits_tag_rob_id;
               slots[i].remaining <= io_alloc_bits_bytes_to_read;
            end else if (io_request_returned_valid && slots[i].state == ACTIVE &&
                         io_request_returned_bits_cmd_id == ID_W'(i)) begin
               if (io_request_returned_bits_bytes_read >= slots[i].remaining) begin
                  slots[i].remaining <= '0;
                  slots[i].state     <= DONE;
               end else begin
                  slots[i].remaining <= slots[i].remaining - io_request_returned_bits_bytes_read;
               end
            end else if (comp_fire && comp_id == ID_W'(i)) begin
               slots[i].state <= FREE;
            end
         end
         if (ret_error) error_q <= 1'b1;
      end
   end

   generate
      if (IN_ORDER != 0) begin : g_order
         dma_tracker_order_fifo #(
            .DEPTH (NUM_CMDS),
            .W     (ID_W)
         ) u_order_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (alloc_fire),
            .push_data (free_id),
            .pop       (comp_fire),
            .head      (fifo_head),
            .empty     (fifo_empty)
         );
      end else begin : g_no_order
         assign fifo_head  = '0;
         assign fifo_empty = 1'b1;
      end
   endgenerate

   assign io_alloc_ready                   = free_found;
   assign io_alloc_bits_cmd_id             = free_id;
   assign io_cmd_completed_valid           = comp_sel_valid;
   assign io_cmd_completed_bits_tag_rob_id = comp_tag;
   assign io_busy_count                    = busy;
   assign io_error                         = error_q;

endmodule

// File: tb/tb_dma_command_tracker_multi.sv
// Bench for dma_command_tracker_multi: a depth-4 lowest-index tracker and a depth-3 in-order tracker,
// each checked against a slot-level reference model.
module tb_dma_command_tracker_multi;

   localparam int NI       = 2;
   localparam int MAXS     = 4;
   localparam int S_FREE   = 0;
   localparam int S_ACTIVE = 1;
   localparam int S_DONE   = 2;
   localparam int BUDGET   = 60;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        alloc_valid [NI];
   logic [5:0]  alloc_tag   [NI];
   logic [14:0] alloc_bytes [NI];
   logic        ret_valid   [NI];
   logic [14:0] ret_bytes   [NI];
   logic [1:0]  ret_id      [NI];
   logic        comp_ready  [NI];

   logic        o0_ready, o1_ready, o0_valid, o1_valid, o0_err, o1_err;
   logic [1:0]  o0_id, o1_id;
   logic [5:0]  o0_tag, o1_tag;
   logic [2:0]  o0_busy;
   logic [1:0]  o1_busy;

   logic        dut_ready [NI];
   logic [1:0]  dut_id    [NI];
   logic        dut_valid [NI];
   logic [5:0]  dut_tag   [NI];
   logic [2:0]  dut_busy  [NI];
   logic        dut_err   [NI];

   always_comb begin
      dut_ready[0] = o0_ready;  dut_ready[1] = o1_ready;
      dut_id[0]    = o0_id;     dut_id[1]    = o1_id;
      dut_valid[0] = o0_valid;  dut_valid[1] = o1_valid;
      dut_tag[0]   = o0_tag;    dut_tag[1]   = o1_tag;
      dut_busy[0]  = o0_busy;   dut_busy[1]  = {1'b0, o1_busy};
      dut_err[0]   = o0_err;    dut_err[1]   = o1_err;
   end

   dma_command_tracker_multi #(.NUM_CMDS(4), .TAG_WIDTH(6), .BYTE_WIDTH(15), .IN_ORDER(0)) dut0 (
      .clock                               (clk),
      .reset                               (rst_n),
      .io_alloc_valid                      (alloc_valid[0]),
      .io_alloc_bits_tag_rob_id            (alloc_tag[0]),
      .io_alloc_bits_bytes_to_read         (alloc_bytes[0]),
      .io_alloc_ready                      (o0_ready),
      .io_alloc_bits_cmd_id                (o0_id),
      .io_request_returned_valid           (ret_valid[0]),
      .io_request_returned_bits_bytes_read (ret_bytes[0]),
      .io_request_returned_bits_cmd_id     (ret_id[0]),
      .io_cmd_completed_valid              (o0_valid),
      .io_cmd_completed_bits_tag_rob_id    (o0_tag),
      .io_cmd_completed_ready              (comp_ready[0]),
      .io_busy_count                       (o0_busy),
      .io_error                            (o0_err)
   );

   dma_command_tracker_multi #(.NUM_CMDS(3), .TAG_WIDTH(6), .BYTE_WIDTH(15), .IN_ORDER(1)) dut1 (
      .clock                               (clk),
      .reset                               (rst_n),
      .io_alloc_valid                      (alloc_valid[1]),
      .io_alloc_bits_tag_rob_id            (alloc_tag[1]),
      .io_alloc_bits_bytes_to_read         (alloc_bytes[1]),
      .io_alloc_ready                      (o1_ready),
      .io_alloc_bits_cmd_id                (o1_id),
      .io_request_returned_valid           (ret_valid[1]),
      .io_request_returned_bits_bytes_read (ret_bytes[1]),
      .io_request_returned_bits_cmd_id     (ret_id[1]),
      .io_cmd_completed_valid              (o1_valid),
      .io_cmd_completed_bits_tag_rob_id    (o1_tag),
      .io_cmd_completed_ready              (comp_ready[1]),
      .io_busy_count                       (o1_busy),
      .io_error                            (o1_err)
   );

   // Reference model: per-slot state, tag and remaining bytes, plus allocation order for instance 1.
   int m_state [NI][MAXS];
   int m_tag   [NI][MAXS];
   int m_rem   [NI][MAXS];
   bit m_err   [NI];
   int m_order [$];

   int vectors     = 0;
   int miscompares = 0;

   function automatic int n_slots(int k);
      return (k == 0) ? 4 : 3;
   endfunction

   function automatic int first_free(int k);
      for (int i = 0; i < n_slots(k); i++) if (m_state[k][i] == S_FREE) return i;
      return -1;
   endfunction

   function automatic int shown_slot(int k);
      if (k == 1) begin
         if (m_order.size() != 0 && m_state[1][m_order[0]] == S_DONE) return m_order[0];
         return -1;
      end
      for (int i = 0; i < n_slots(k); i++) if (m_state[k][i] == S_DONE) return i;
      return -1;
   endfunction

   function automatic int busy_count(int k);
      int n = 0;
      for (int i = 0; i < n_slots(k); i++) if (m_state[k][i] != S_FREE) n++;
      return n;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NI; k++) begin
         for (int i = 0; i < MAXS; i++) begin
            m_state[k][i] = S_FREE;
            m_tag[k][i]   = 0;
            m_rem[k][i]   = 0;
         end
         m_err[k] = 1'b0;
      end
      m_order.delete();
   endtask

   task automatic idle();
      for (int k = 0; k < NI; k++) begin
         alloc_valid[k] = 1'b0; alloc_tag[k] = '0; alloc_bytes[k] = '0;
         ret_valid[k]   = 1'b0; ret_bytes[k] = '0; ret_id[k]      = '0;
         comp_ready[k]  = 1'b0;
      end
   endtask

   // Advance the model with the currently driven inputs, then let the DUTs take the same clock edge.
   task automatic step();
      for (int k = 0; k < NI; k++) begin
         int ff, cs, id;
         ff = first_free(k);
         cs = shown_slot(k);
         if (ret_valid[k]) begin
            id = int'(ret_id[k]);
            if (id >= n_slots(k) || m_state[k][id] != S_ACTIVE) begin
               m_err[k] = 1'b1;
            end else if (int'(ret_bytes[k]) > m_rem[k][id]) begin
               m_rem[k][id]   = 0;
               m_state[k][id] = S_DONE;
               m_err[k]       = 1'b1;
            end else begin
               m_rem[k][id] -= int'(ret_bytes[k]);
               if (m_rem[k][id] == 0) m_state[k][id] = S_DONE;
            end
         end
         if (cs >= 0 && comp_ready[k]) begin
            m_state[k][cs] = S_FREE;
            if (k == 1) void'(m_order.pop_front());
         end
         if (alloc_valid[k] && ff >= 0) begin
            m_state[k][ff] = (alloc_bytes[k] == 0) ? S_DONE : S_ACTIVE;
            m_tag[k][ff]   = int'(alloc_tag[k]);
            m_rem[k][ff]   = int'(alloc_bytes[k]);
            if (k == 1) m_order.push_back(ff);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic set_alloc(int k, int tag, int bytes);
      alloc_valid[k] = 1'b1;
      alloc_tag[k]   = 6'(tag);
      alloc_bytes[k] = 15'(bytes);
   endtask

   task automatic set_ret(int k, int id, int bytes);
      ret_valid[k] = 1'b1;
      ret_id[k]    = 2'(id);
      ret_bytes[k] = 15'(bytes);
   endtask

   // Retire everything still held by instance k, bounded by a cycle budget.
   task automatic drain(int k);
      int cycles = 0;
      while (busy_count(k) != 0 && cycles < BUDGET) begin
         idle();
         for (int i = 0; i < n_slots(k); i++) begin
            if (m_state[k][i] == S_ACTIVE) begin
               set_ret(k, i, m_rem[k][i]);
               break;
            end
         end
         comp_ready[k] = 1'b1;
         step();
         cycles++;
      end
      idle();
      vectors++;
      if (dut_busy[k] !== 3'd0 || busy_count(k) != 0) begin
         miscompares++;
         $display("FAIL drain[%0d]: busy got %0d model %0d want 0 after %0d cycles", k, dut_busy[k], busy_count(k), cycles);
      end
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      model_clear();
      #2;
      for (int k = 0; k < NI; k++) begin
         vectors += 6;
         if (dut_ready[k] !== 1'b1) begin miscompares++; $display("FAIL reset_ready[%0d]: got %b want 1", k, dut_ready[k]); end
         if (dut_id[k]    !== 2'd0) begin miscompares++; $display("FAIL reset_id[%0d]: got %0d want 0", k, dut_id[k]); end
         if (dut_valid[k] !== 1'b0) begin miscompares++; $display("FAIL reset_valid[%0d]: got %b want 0", k, dut_valid[k]); end
         if (dut_tag[k]   !== 6'd0) begin miscompares++; $display("FAIL reset_tag[%0d]: got %0d want 0", k, dut_tag[k]); end
         if (dut_busy[k]  !== 3'd0) begin miscompares++; $display("FAIL reset_busy[%0d]: got %0d want 0", k, dut_busy[k]); end
         if (dut_err[k]   !== 1'b0) begin miscompares++; $display("FAIL reset_error[%0d]: got %b want 0", k, dut_err[k]); end
      end
      do_reset();
   endtask

   task automatic test_basic();
      idle();
      set_alloc(0, 5, 64);
      vectors += 2;
      if (dut_ready[0] !== 1'b1) begin miscompares++; $display("FAIL basic_ready: got %b want 1", dut_ready[0]); end
      if (dut_id[0]    !== 2'd0) begin miscompares++; $display("FAIL basic_id: got %0d want 0", dut_id[0]); end
      step(); idle();
      vectors += 2;
      if (dut_busy[0]  !== 3'd1) begin miscompares++; $display("FAIL basic_busy: got %0d want 1", dut_busy[0]); end
      if (dut_valid[0] !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid: got %b want 0", dut_valid[0]); end
      set_ret(0, 0, 32);
      step();
      vectors++;
      if (dut_valid[0] !== 1'b0) begin miscompares++; $display("FAIL basic_half_valid: got %b want 0", dut_valid[0]); end
      step(); idle();
      vectors += 2;
      if (dut_valid[0] !== 1'b1) begin miscompares++; $display("FAIL basic_done_valid: got %b want 1", dut_valid[0]); end
      if (dut_tag[0]   !== 6'd5) begin miscompares++; $display("FAIL basic_done_tag: got %0d want 5", dut_tag[0]); end
      comp_ready[0] = 1'b1;
      step(); idle();
      vectors += 2;
      if (dut_busy[0]  !== 3'd0) begin miscompares++; $display("FAIL basic_busy_after: got %0d want 0", dut_busy[0]); end
      if (dut_valid[0] !== 1'b0) begin miscompares++; $display("FAIL basic_valid_after: got %b want 0", dut_valid[0]); end
   endtask

   task automatic test_full_realloc();
      for (int i = 0; i < 4; i++) begin
         idle();
         set_alloc(0, 10 + i, 100);
         step();
      end
      idle();
      vectors += 2;
      if (dut_ready[0] !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b want 0", dut_ready[0]); end
      if (dut_busy[0]  !== 3'd4) begin miscompares++; $display("FAIL full_busy: got %0d want 4", dut_busy[0]); end
      set_ret(0, 2, 100);
      step(); idle();
      vectors += 2;
      if (dut_valid[0] !== 1'b1)  begin miscompares++; $display("FAIL full_comp_valid: got %b want 1", dut_valid[0]); end
      if (dut_tag[0]   !== 6'd12) begin miscompares++; $display("FAIL full_comp_tag: got %0d want 12", dut_tag[0]); end
      comp_ready[0] = 1'b1;
      step(); idle();
      vectors += 2;
      if (dut_ready[0] !== 1'b1) begin miscompares++; $display("FAIL realloc_ready: got %b want 1", dut_ready[0]); end
      if (dut_id[0]    !== 2'd2) begin miscompares++; $display("FAIL realloc_id: got %0d want 2", dut_id[0]); end
      drain(0);
   endtask

   task automatic test_zero_bytes();
      idle();
      set_alloc(0, 9, 0);
      step(); idle();
      vectors += 2;
      if (dut_valid[0] !== 1'b1) begin miscompares++; $display("FAIL zero_valid: got %b want 1", dut_valid[0]); end
      if (dut_tag[0]   !== 6'd9) begin miscompares++; $display("FAIL zero_tag: got %0d want 9", dut_tag[0]); end
      comp_ready[0] = 1'b1;
      step(); idle();
      vectors++;
      if (dut_busy[0] !== 3'd0) begin miscompares++; $display("FAIL zero_busy: got %0d want 0", dut_busy[0]); end
   endtask

   task automatic test_in_order();
      idle();
      for (int k = 0; k < NI; k++) set_alloc(k, 20, 8);
      step(); idle();
      for (int k = 0; k < NI; k++) set_alloc(k, 21, 8);
      step(); idle();
      for (int k = 0; k < NI; k++) set_ret(k, 1, 8);
      step(); idle();
      for (int c = 0; c < 2; c++) begin
         vectors += 3;
         if (dut_valid[0] !== 1'b1)  begin miscompares++; $display("FAIL ooo_young_valid: got %b want 1", dut_valid[0]); end
         if (dut_tag[0]   !== 6'd21) begin miscompares++; $display("FAIL ooo_young_tag: got %0d want 21", dut_tag[0]); end
         if (dut_valid[1] !== 1'b0)  begin miscompares++; $display("FAIL ino_young_waits: got %b want 0", dut_valid[1]); end
         step();
      end
      comp_ready[0] = 1'b1;
      step(); idle();
      for (int k = 0; k < NI; k++) set_ret(k, 0, 8);
      step(); idle();
      for (int k = 0; k < NI; k++) begin
         vectors += 2;
         if (dut_valid[k] !== 1'b1)  begin miscompares++; $display("FAIL order_old_valid[%0d]: got %b want 1", k, dut_valid[k]); end
         if (dut_tag[k]   !== 6'd20) begin miscompares++; $display("FAIL order_old_tag[%0d]: got %0d want 20", k, dut_tag[k]); end
      end
      comp_ready[0] = 1'b1;
      comp_ready[1] = 1'b1;
      step(); idle();
      vectors += 3;
      if (dut_valid[0] !== 1'b0)  begin miscompares++; $display("FAIL ooo_empty_valid: got %b want 0", dut_valid[0]); end
      if (dut_valid[1] !== 1'b1)  begin miscompares++; $display("FAIL ino_second_valid: got %b want 1", dut_valid[1]); end
      if (dut_tag[1]   !== 6'd21) begin miscompares++; $display("FAIL ino_second_tag: got %0d want 21", dut_tag[1]); end
      comp_ready[1] = 1'b1;
      step(); idle();
      for (int k = 0; k < NI; k++) begin
         vectors++;
         if (dut_busy[k] !== 3'd0) begin miscompares++; $display("FAIL order_busy[%0d]: got %0d want 0", k, dut_busy[k]); end
      end
   endtask

   task automatic test_stall_and_reset();
      idle();
      set_alloc(0, 30, 0);
      set_alloc(1, 31, 50);
      step(); idle();
      set_alloc(0, 31, 0);
      step(); idle();
      for (int c = 0; c < 5; c++) begin
         vectors += 3;
         if (dut_valid[0] !== 1'b1)  begin miscompares++; $display("FAIL stall_valid[%0d]: got %b want 1", c, dut_valid[0]); end
         if (dut_tag[0]   !== 6'd30) begin miscompares++; $display("FAIL stall_tag[%0d]: got %0d want 30", c, dut_tag[0]); end
         if (dut_busy[0]  !== 3'd2)  begin miscompares++; $display("FAIL stall_busy[%0d]: got %0d want 2", c, dut_busy[0]); end
         step();
      end
      // Assert reset between clock edges: outputs must drop without waiting for clk.
      #2 rst_n = 1'b0;
      model_clear();
      #1;
      for (int k = 0; k < NI; k++) begin
         vectors += 5;
         if (dut_ready[k] !== 1'b1) begin miscompares++; $display("FAIL midrst_ready[%0d]: got %b want 1", k, dut_ready[k]); end
         if (dut_id[k]    !== 2'd0) begin miscompares++; $display("FAIL midrst_id[%0d]: got %0d want 0", k, dut_id[k]); end
         if (dut_valid[k] !== 1'b0) begin miscompares++; $display("FAIL midrst_valid[%0d]: got %b want 0", k, dut_valid[k]); end
         if (dut_tag[k]   !== 6'd0) begin miscompares++; $display("FAIL midrst_tag[%0d]: got %0d want 0", k, dut_tag[k]); end
         if (dut_busy[k]  !== 3'd0) begin miscompares++; $display("FAIL midrst_busy[%0d]: got %0d want 0", k, dut_busy[k]); end
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 400; cyc++) begin
         idle();
         for (int k = 0; k < NI; k++) begin
            int act [$];
            int id, ff, cs;
            alloc_valid[k] = ($urandom_range(0, 1) == 1);
            alloc_tag[k]   = 6'($urandom);
            alloc_bytes[k] = ($urandom_range(0, 7) == 0) ? 15'd0 : 15'($urandom_range(1, 48));
            for (int i = 0; i < n_slots(k); i++) if (m_state[k][i] == S_ACTIVE) act.push_back(i);
            if (act.size() != 0 && $urandom_range(0, 9) < 6) begin
               id = act[$urandom_range(0, act.size() - 1)];
               if ($urandom_range(0, 19) == 0) set_ret(k, id, m_rem[k][id] + int'($urandom_range(1, 5)));
               else                            set_ret(k, id, int'($urandom_range(1, m_rem[k][id])));
            end else if ($urandom_range(0, 29) == 0) begin
               set_ret(k, int'($urandom_range(0, 3)), int'($urandom_range(0, 20)));
            end
            comp_ready[k] = ($urandom_range(0, 3) != 0);

            ff = first_free(k);
            cs = shown_slot(k);
            vectors += 4;
            if (dut_ready[k] !== (ff >= 0)) begin miscompares++; $display("FAIL rand_ready[%0d] cyc %0d: got %b want %b", k, cyc, dut_ready[k], ff >= 0); end
            if (dut_valid[k] !== (cs >= 0)) begin miscompares++; $display("FAIL rand_valid[%0d] cyc %0d: got %b want %b", k, cyc, dut_valid[k], cs >= 0); end
            if (dut_busy[k] !== 3'(busy_count(k))) begin miscompares++; $display("FAIL rand_busy[%0d] cyc %0d: got %0d want %0d", k, cyc, dut_busy[k], busy_count(k)); end
            if (dut_err[k] !== m_err[k]) begin miscompares++; $display("FAIL rand_error[%0d] cyc %0d: got %b want %b", k, cyc, dut_err[k], m_err[k]); end
            if (ff >= 0) begin
               vectors++;
               if (dut_id[k] !== 2'(ff)) begin miscompares++; $display("FAIL rand_id[%0d] cyc %0d: got %0d want %0d", k, cyc, dut_id[k], ff); end
            end
            if (cs >= 0) begin
               vectors++;
               if (dut_tag[k] !== 6'(m_tag[k][cs])) begin miscompares++; $display("FAIL rand_tag[%0d] cyc %0d: got %0d want %0d", k, cyc, dut_tag[k], m_tag[k][cs]); end
            end
         end
         step();
      end
      drain(0);
      drain(1);
   endtask

   task automatic test_error();
      do_reset();
      vectors += 2;
      if (dut_err[0] !== 1'b0) begin miscompares++; $display("FAIL err_initial[0]: got %b want 0", dut_err[0]); end
      if (dut_err[1] !== 1'b0) begin miscompares++; $display("FAIL err_initial[1]: got %b want 0", dut_err[1]); end
      set_alloc(0, 3, 16);
      step(); idle();
      set_ret(0, 0, 40);
      step(); idle();
      vectors += 4;
      if (dut_err[0]   !== 1'b1) begin miscompares++; $display("FAIL overrun_error: got %b want 1", dut_err[0]); end
      if (dut_valid[0] !== 1'b1) begin miscompares++; $display("FAIL overrun_valid: got %b want 1", dut_valid[0]); end
      if (dut_tag[0]   !== 6'd3) begin miscompares++; $display("FAIL overrun_tag: got %0d want 3", dut_tag[0]); end
      if (dut_busy[0]  !== 3'd1) begin miscompares++; $display("FAIL overrun_busy: got %0d want 1", dut_busy[0]); end
      comp_ready[0] = 1'b1;
      step(); idle();
      set_ret(0, 0, 5);
      step(); idle();
      repeat (3) step();
      vectors += 3;
      if (dut_err[0]   !== 1'b1) begin miscompares++; $display("FAIL free_ret_error: got %b want 1", dut_err[0]); end
      if (dut_busy[0]  !== 3'd0) begin miscompares++; $display("FAIL free_ret_busy: got %0d want 0", dut_busy[0]); end
      if (dut_valid[0] !== 1'b0) begin miscompares++; $display("FAIL free_ret_valid: got %b want 0", dut_valid[0]); end
      set_ret(1, 3, 1);
      step(); idle();
      vectors += 2;
      if (dut_err[1]  !== 1'b1) begin miscompares++; $display("FAIL range_error: got %b want 1", dut_err[1]); end
      if (dut_busy[1] !== 3'd0) begin miscompares++; $display("FAIL range_busy: got %0d want 0", dut_busy[1]); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_realloc();
      test_zero_bytes();
      test_in_order();
      test_stall_and_reset();
      test_random();
      test_error();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
